// File: rtl/ahb_lite_regfile.sv
// ahb_lite_regfile
//
// Register-file responder for the 8-bit AHB-Lite style bus. DEPTH byte-wide
// registers are read and written through the pipelined address phase /
// data phase protocol. Out-of-range addresses get the two-cycle ERROR response.
//
// Optional feature macro: REGFILE_WAIT_EN
//   defined   -> every in-range transfer stalls WAIT_CYCLES cycles (WAIT state
//                plus 4-bit down counter)
//   undefined -> all in-range transfers are zero-wait; WAIT_CYCLES is unused
//
// Parameters
//   DEPTH        number of registers, power of two, 2..256
//   WAIT_CYCLES  data-phase stall cycles per OK transfer, 1..15
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   sel       in   subordinate select
//   trans     in   transfer request (address phase)
//   write     in   1 = write, 0 = read (address phase)
//   addr      in   byte address (address phase)
//   wdata     in   write data (data phase)
//   ready     in   bus ready; the address phase is sampled only when high
//   readyout  out  1 = data phase completes this cycle
//   resp      out  0 = OKAY, 1 = ERROR
//   rdata     out  registered read data

module ahb_lite_regfile #(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sel,
    input  logic       trans,
    input  logic       write,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       ready,
    output logic       readyout,
    output logic       resp,
    output logic [7:0] rdata
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("ahb_lite_regfile: DEPTH must be a power of two in 2..256");
    end
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_wait_chk
        $error("ahb_lite_regfile: WAIT_CYCLES must be in 1..15");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DATA = 3'd1,
        ERR1 = 3'd2,
        ERR2 = 3'd3
`ifdef REGFILE_WAIT_EN
        ,
        WAIT = 3'd4
`endif
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] addr_q;
    logic          write_q;
`ifdef REGFILE_WAIT_EN
    logic [3:0]    cnt;
`endif

    logic          req;
    logic          in_range;
    logic [AW-1:0] aidx;
    logic          commit;
    logic [7:0]    rd_fwd;

    assign req      = sel & trans & ready;
    // Upper address bits matter only here; the register index drops them.
    assign in_range = ({1'b0, addr} < 9'(DEPTH));
    assign aidx     = addr[AW-1:0];
    // A DATA cycle of a write commits at the edge that ends it.
    assign commit   = (state == DATA) && write_q;
    // A read entering DATA at the same edge as a write commit to the same
    // register must see the new value, not the stale array entry.
    assign rd_fwd   = (commit && (addr_q == aidx)) ? wdata : mem[aidx];

    // Address phase / data phase control and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            readyout <= 1'b1;
            resp     <= 1'b0;
            rdata    <= 8'h00;
            addr_q   <= '0;
            write_q  <= 1'b0;
`ifdef REGFILE_WAIT_EN
            cnt      <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE, DATA, ERR2: begin
                    if (req) begin
                        addr_q  <= aidx;
                        write_q <= write;
                        if (!in_range) begin
                            state    <= ERR1;
                            readyout <= 1'b0;
                            resp     <= 1'b1;
                        end else begin
`ifdef REGFILE_WAIT_EN
                            state    <= WAIT;
                            cnt      <= 4'(WAIT_CYCLES);
                            readyout <= 1'b0;
                            resp     <= 1'b0;
`else
                            state    <= DATA;
                            readyout <= 1'b1;
                            resp     <= 1'b0;
                            if (!write) begin
                                rdata <= rd_fwd;
                            end
`endif
                        end
                    end else begin
                        state    <= IDLE;
                        readyout <= 1'b1;
                        resp     <= 1'b0;
                    end
                end
`ifdef REGFILE_WAIT_EN
                WAIT: begin
                    // No commit can coincide with leaving WAIT, so no forwarding.
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state    <= DATA;
                        readyout <= 1'b1;
                        resp     <= 1'b0;
                        if (!write_q) begin
                            rdata <= mem[addr_q];
                        end
                    end
                end
`endif
                ERR1: begin
                    state    <= ERR2;
                    readyout <= 1'b1;
                    resp     <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    readyout <= 1'b1;
                    resp     <= 1'b0;
                end
            endcase
        end
    end

    // Register array write port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (commit) begin
            mem[addr_q] <= wdata;
        end
    end

endmodule

// File: tb/tb_ahb_lite_regfile.sv
module tb_ahb_lite_regfile;

    logic       clock = 1'b0;
    logic       reset;
    logic       sel, trans, write, ready;
    logic [7:0] addr, wdata;
    logic       readyout, resp;
    logic [7:0] rdata;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    ahb_lite_regfile #(
        .DEPTH      (16),
        .WAIT_CYCLES(2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .sel     (sel),
        .trans   (trans),
        .write   (write),
        .addr    (addr),
        .wdata   (wdata),
        .ready   (ready),
        .readyout(readyout),
        .resp    (resp),
        .rdata   (rdata)
    );

    typedef struct {
        logic       sel;
        logic       trans;
        logic       write;
        logic       ready;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       e_ro;
        logic       e_resp;
        logic [7:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic t, input logic w, input logic r,
                                input logic [7:0] a, input logic [7:0] d,
                                input logic ero, input logic eresp, input logic [7:0] erd);
        vec_t v;
        v.sel = s; v.trans = t; v.write = w; v.ready = r;
        v.addr = a; v.wdata = d;
        v.e_ro = ero; v.e_resp = eresp; v.e_rdata = erd;
        return v;
    endfunction

    task automatic check(input string nm, input logic ero, input logic eresp, input logic [7:0] erd);
        checks++;
        if (readyout !== ero) begin
            errors++;
            $display("FAIL %s readyout: got %b expected %b", nm, readyout, ero);
        end
        checks++;
        if (resp !== eresp) begin
            errors++;
            $display("FAIL %s resp: got %b expected %b", nm, resp, eresp);
        end
        checks++;
        if (rdata !== erd) begin
            errors++;
            $display("FAIL %s rdata: got %02h expected %02h", nm, rdata, erd);
        end
    endtask

    // Drive one cycle of bus inputs, clock it, then check just after the edge.
    task automatic step(input string nm, input logic s, input logic t, input logic w,
                        input logic r, input logic [7:0] a, input logic [7:0] d,
                        input logic ero, input logic eresp, input logic [7:0] erd);
        sel = s; trans = t; write = w; ready = r; addr = a; wdata = d;
        @(posedge clock);
        #1;
        check(nm, ero, eresp, erd);
    endtask

    vec_t tbl[22];

    initial begin
        reset = 1'b1;
        sel = 1'b0; trans = 1'b0; write = 1'b0; ready = 1'b1;
        addr = 8'h00; wdata = 8'h00;
        #2;
        check("reset_async", 1'b1, 1'b0, 8'h00);
        @(posedge clock);
        #1;
        check("reset_held", 1'b1, 1'b0, 8'h00);
        reset = 1'b0;

`ifndef REGFILE_WAIT_EN
        //           sel trn wr  rdy addr   wdata   ro   resp rdata
        tbl[0]  = mk(1, 1, 0, 1, 8'h05, 8'h00, 1, 0, 8'h00); // read 5 after reset
        tbl[1]  = mk(1, 1, 1, 1, 8'h03, 8'h00, 1, 0, 8'h00); // write 3
        tbl[2]  = mk(0, 0, 0, 1, 8'h00, 8'hA5, 1, 0, 8'h00); // data A5, idle
        tbl[3]  = mk(1, 1, 0, 1, 8'h03, 8'h00, 1, 0, 8'hA5); // read 3
        tbl[4]  = mk(1, 1, 1, 1, 8'h07, 8'h00, 1, 0, 8'hA5); // write 7
        tbl[5]  = mk(1, 1, 0, 1, 8'h07, 8'h3C, 1, 0, 8'h3C); // read 7, forwarded
        tbl[6]  = mk(0, 0, 0, 1, 8'h00, 8'h00, 1, 0, 8'h3C); // idle holds
        tbl[7]  = mk(1, 1, 1, 1, 8'h10, 8'h00, 0, 1, 8'h3C); // write 16 -> ERR1
        tbl[8]  = mk(1, 1, 1, 0, 8'h03, 8'hFF, 1, 1, 8'h3C); // ERR2, inputs ignored
        tbl[9]  = mk(1, 1, 0, 1, 8'h00, 8'hFF, 1, 0, 8'h00); // read 0 during ERR2
        tbl[10] = mk(1, 1, 0, 1, 8'h03, 8'h00, 1, 0, 8'hA5); // back-to-back read 3
        tbl[11] = mk(1, 1, 1, 1, 8'h0F, 8'h00, 1, 0, 8'hA5); // write 15
        tbl[12] = mk(1, 1, 0, 1, 8'h0F, 8'h5A, 1, 0, 8'h5A); // read 15, forwarded
        tbl[13] = mk(1, 1, 1, 1, 8'h03, 8'h00, 1, 0, 8'h5A); // write 3
        tbl[14] = mk(1, 1, 0, 1, 8'h07, 8'h77, 1, 0, 8'h3C); // read 7, no forward
        tbl[15] = mk(1, 1, 0, 1, 8'h03, 8'h00, 1, 0, 8'h77); // read 3 new value
        tbl[16] = mk(0, 0, 0, 1, 8'h00, 8'h00, 1, 0, 8'h77); // idle holds
        tbl[17] = mk(0, 1, 0, 1, 8'h0F, 8'h00, 1, 0, 8'h77); // sel low ignored
        tbl[18] = mk(1, 1, 0, 0, 8'h0F, 8'h00, 1, 0, 8'h77); // ready low ignored
        tbl[19] = mk(1, 1, 0, 1, 8'h8F, 8'h00, 0, 1, 8'h77); // upper bits -> ERR1
        tbl[20] = mk(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h77); // ERR2
        tbl[21] = mk(0, 0, 0, 1, 8'h00, 8'h00, 1, 0, 8'h77); // back to IDLE

        for (int i = 0; i < 22; i++) begin
            step($sformatf("vec%0d", i), tbl[i].sel, tbl[i].trans, tbl[i].write, tbl[i].ready,
                 tbl[i].addr, tbl[i].wdata, tbl[i].e_ro, tbl[i].e_resp, tbl[i].e_rdata);
        end

        // Reset in the DATA cycle of a write: write is dropped, registers cleared.
        step("rst_wr4", 1, 1, 1, 1, 8'h04, 8'h00, 1'b1, 1'b0, 8'h77);
        sel = 1'b0; trans = 1'b0; write = 1'b0; wdata = 8'h55;
        #2;
        reset = 1'b1;
        #1;
        check("rst_in_data", 1'b1, 1'b0, 8'h00);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step("rst_rd4", 1, 1, 0, 1, 8'h04, 8'h00, 1'b1, 1'b0, 8'h00);
        step("rst_rd3", 1, 1, 0, 1, 8'h03, 8'h00, 1'b1, 1'b0, 8'h00);
        step("rst_idle", 0, 0, 0, 1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
`else
        // Waited write of 0x11 to addr 2, then waited read back.
        step("w_wr2_a",  1, 1, 1, 1, 8'h02, 8'h00, 1'b0, 1'b0, 8'h00);
        step("w_wr2_w1", 0, 0, 0, 0, 8'h00, 8'h11, 1'b0, 1'b0, 8'h00);
        step("w_wr2_w2", 0, 0, 0, 0, 8'h00, 8'h11, 1'b1, 1'b0, 8'h00);
        step("w_rd2_a",  1, 1, 0, 1, 8'h02, 8'h11, 1'b0, 1'b0, 8'h00);
        step("w_rd2_w1", 0, 0, 0, 0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        step("w_rd2_w2", 0, 0, 0, 0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h11);
        step("w_idle",   0, 0, 0, 1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h11);
        // Error timing is unchanged by the wait option.
        step("w_err1",   1, 1, 1, 1, 8'h10, 8'h00, 1'b0, 1'b1, 8'h11);
        step("w_err2",   0, 0, 0, 0, 8'h00, 8'hFF, 1'b1, 1'b1, 8'h11);
        step("w_rd0_a",  1, 1, 0, 1, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h11);
        step("w_rd0_w1", 0, 0, 0, 0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h11);
        step("w_rd0_w2", 0, 0, 0, 0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        step("w_rd2b_a", 1, 1, 0, 1, 8'h02, 8'h00, 1'b0, 1'b0, 8'h00);
        step("w_rd2b_1", 0, 0, 0, 0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        step("w_rd2b_2", 0, 0, 0, 0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h11);
        // Reset in the first WAIT cycle of a write of 0x55 to addr 4.
        step("w_wr4_a",  1, 1, 1, 1, 8'h04, 8'h00, 1'b0, 1'b0, 8'h11);
        sel = 1'b0; trans = 1'b0; write = 1'b0; ready = 1'b0; wdata = 8'h55;
        #2;
        reset = 1'b1;
        #1;
        check("w_rst_in_wait", 1'b1, 1'b0, 8'h00);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step("w_rd4_a",  1, 1, 0, 1, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00);
        step("w_rd4_w1", 0, 0, 0, 0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        step("w_rd4_w2", 0, 0, 0, 0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        step("w_rd2c_a", 1, 1, 0, 1, 8'h02, 8'h00, 1'b0, 1'b0, 8'h00);
        step("w_rd2c_1", 0, 0, 0, 0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        step("w_rd2c_2", 0, 0, 0, 0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
